// File: rtl/gcn_pkg.sv
// Shared types, width helpers and default sizing for the GCN inference engine.
package gcn_pkg;

    localparam int DEF_N_NODES = 6;
    localparam int DEF_N_FEAT  = 96;
    localparam int DEF_N_CLASS = 3;
    localparam int DEF_N_EDGES = 6;
    localparam int DEF_BW      = 5;
    localparam int DEF_LANES   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADJ,
        S_LOADW,
        S_XFORM,
        S_AGG,
        S_WRITE,
        S_FIN
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_CAP,
        PH_MAC
    } xphase_t;

    // Node index width for the 1-based COO entries (0 is padding).
    function automatic int iw_f(input int n_nodes);
        return $clog2(n_nodes + 1);
    endfunction

    // Transformed-feature width: full product plus carry room for every feature.
    function automatic int tw_f(input int bw, input int n_feat);
        return 2 * bw + $clog2(n_feat);
    endfunction

    // Aggregated width: room to sum one T value from every node.
    function automatic int ow_f(input int tw, input int n_nodes);
        return tw + $clog2(n_nodes + 1);
    endfunction

endpackage

// File: rtl/gcn_dot_lanes.sv
// LANES-wide unsigned multiply, adder tree and accumulator; o_next is the
// running dot product including the current chunk.
module gcn_dot_lanes #(
    parameter int LANES = 8,
    parameter int BW    = 5,
    parameter int ACCW  = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [LANES*BW-1:0]   i_a,
    input  logic [LANES*BW-1:0]   i_b,
    output logic [ACCW-1:0]       o_next
);

    localparam int PW = 2 * BW;

    logic [ACCW-1:0] r_acc;
    logic [ACCW-1:0] w_tree;

    // NOTE: every always_comb target gets a default first so no latch can be inferred.
    always_comb begin
        w_tree = '0;
        for (int l = 0; l < LANES; l++) begin
            w_tree = w_tree + ACCW'(PW'(i_a[l*BW +: BW]) * PW'(i_b[l*BW +: BW]));
        end
    end

    // i_clr starts a fresh sum with this chunk instead of adding to the old one.
    assign o_next = (i_clr ? '0 : r_acc) + w_tree;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_next;
        end
    end

endmodule

// File: rtl/gcn_engine.sv
// One GCN layer (A * (X * W^T)) plus per-node argmax over a COO-described graph.
// Build option: define GCN_SELF_LOOP_EN to add the identity to the adjacency.
module gcn_engine
    import gcn_pkg::*;
#(
    parameter int N_NODES = DEF_N_NODES,
    parameter int N_FEAT  = DEF_N_FEAT,
    parameter int N_CLASS = DEF_N_CLASS,
    parameter int N_EDGES = DEF_N_EDGES,
    parameter int BW      = DEF_BW,
    parameter int LANES   = DEF_LANES
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic [N_EDGES*$clog2(N_NODES+1)-1:0]     coo_src,
    input  logic [N_EDGES*$clog2(N_NODES+1)-1:0]     coo_dst,
    output logic                                     fm_re,
    output logic [$clog2(N_NODES)-1:0]               fm_addr,
    input  logic [N_FEAT*BW-1:0]                     fm_rdata,
    output logic                                     wm_re,
    output logic [$clog2(N_CLASS)-1:0]               wm_addr,
    input  logic [N_FEAT*BW-1:0]                     wm_rdata,
    output logic                                     y_we,
    output logic [$clog2(N_NODES)-1:0]               y_addr,
    output logic [$clog2(N_CLASS)-1:0]               y_class,
    output logic                                     busy,
    output logic                                     done
);

    localparam int IW   = iw_f(N_NODES);
    localparam int AW   = $clog2(N_NODES);
    localparam int CLW  = $clog2(N_CLASS);
    localparam int TW   = tw_f(BW, N_FEAT);
    localparam int OW   = ow_f(TW, N_NODES);
    localparam int RW   = N_FEAT * BW;
    localparam int NCH  = N_FEAT / LANES;
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNTW = $clog2(((N_EDGES > N_CLASS) ? N_EDGES : N_CLASS) + 1);

    state_t                          r_state;
    xphase_t                         r_phase;
    logic [N_EDGES*IW-1:0]           r_src;
    logic [N_EDGES*IW-1:0]           r_dst;
    logic [N_NODES-1:0][N_NODES-1:0] r_adj;
    logic [CNTW-1:0]                 r_cnt;
    logic [AW-1:0]                   r_i;
    logic [CLW-1:0]                  r_j;
    logic [CHW-1:0]                  r_chunk;

    logic [RW-1:0]                   r_xrow;
    logic [RW-1:0]                   r_wbuf [N_CLASS];
    logic [TW-1:0]                   r_t    [N_NODES][N_CLASS];
    logic [OW-1:0]                   r_o    [N_NODES][N_CLASS];

    logic [IW-1:0]                   w_s;
    logic [IW-1:0]                   w_d;
    logic [AW-1:0]                   w_si;
    logic [AW-1:0]                   w_di;
    logic                            w_edge_ok;
    logic                            w_mac;
    logic                            w_last_chunk;
    logic                            w_last_cls;
    logic                            w_last_node;
    logic [LANES*BW-1:0]             w_a;
    logic [LANES*BW-1:0]             w_b;
    logic [TW-1:0]                   w_dot;
    logic [OW-1:0]                   w_agg;
    logic [OW-1:0]                   w_best_val;
    logic [CLW-1:0]                  w_best;

    // Current COO slot; padding and out-of-range indices never touch the adjacency.
    assign w_s       = r_src[int'(r_cnt)*IW +: IW];
    assign w_d       = r_dst[int'(r_cnt)*IW +: IW];
    assign w_si      = AW'(w_s - 1'b1);
    assign w_di      = AW'(w_d - 1'b1);
    assign w_edge_ok = (w_s != '0) && (w_d != '0) &&
                       (int'(w_s) <= N_NODES) && (int'(w_d) <= N_NODES);

    assign w_mac        = (r_state == S_XFORM) && (r_phase == PH_MAC);
    assign w_last_chunk = (int'(r_chunk) == NCH - 1);
    assign w_last_cls   = (int'(r_j) == N_CLASS - 1);
    assign w_last_node  = (int'(r_i) == N_NODES - 1);

    assign w_a = r_xrow[int'(r_chunk)*LANES*BW +: LANES*BW];
    assign w_b = r_wbuf[r_j][int'(r_chunk)*LANES*BW +: LANES*BW];

    gcn_dot_lanes #(
        .LANES (LANES),
        .BW    (BW),
        .ACCW  (TW)
    ) u_dot (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (r_chunk == '0),
        .i_en   (w_mac),
        .i_a    (w_a),
        .i_b    (w_b),
        .o_next (w_dot)
    );

    always_comb begin
        w_agg = '0;
        for (int k = 0; k < N_NODES; k++) begin
            if (r_adj[r_i][k]) begin
                w_agg = w_agg + OW'(r_t[k][r_j]);
            end
        end
    end

    // Strict '>' keeps the lowest class index on ties.
    always_comb begin
        w_best     = '0;
        w_best_val = r_o[r_i][0];
        for (int j = 1; j < N_CLASS; j++) begin
            if (r_o[r_i][j] > w_best_val) begin
                w_best_val = r_o[r_i][j];
                w_best     = CLW'(j);
            end
        end
    end

    // NOTE: data arrays carry no reset; every entry is written before it is read in a run.
    always_ff @(posedge clk) begin
        if (r_state == S_LOADW && r_cnt != '0) begin
            r_wbuf[CLW'(r_cnt - 1'b1)] <= wm_rdata;
        end
        if (r_state == S_XFORM && r_phase == PH_CAP) begin
            r_xrow <= fm_rdata;
        end
        if (w_mac && w_last_chunk) begin
            r_t[r_i][r_j] <= w_dot;
        end
        if (r_state == S_AGG) begin
            r_o[r_i][r_j] <= w_agg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_phase <= PH_ISSUE;
            r_src   <= '0;
            r_dst   <= '0;
            r_adj   <= '0;
            r_cnt   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_chunk <= '0;
            fm_re   <= 1'b0;
            fm_addr <= '0;
            wm_re   <= 1'b0;
            wm_addr <= '0;
            y_we    <= 1'b0;
            y_addr  <= '0;
            y_class <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            fm_re <= 1'b0;
            wm_re <= 1'b0;
            y_we  <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_src   <= coo_src;
                    r_dst   <= coo_dst;
                    r_adj   <= '0;
                    r_cnt   <= '0;
                    busy    <= 1'b1;
                    r_state <= S_ADJ;
                end
                S_ADJ: begin
                    if (w_edge_ok) begin
                        r_adj[w_si][w_di] <= 1'b1;
                        r_adj[w_di][w_si] <= 1'b1;
                    end
                    if (int'(r_cnt) == N_EDGES - 1) begin
`ifdef GCN_SELF_LOOP_EN
                        for (int k = 0; k < N_NODES; k++) begin
                            r_adj[k][k] <= 1'b1;
                        end
`endif
                        r_cnt   <= '0;
                        wm_re   <= 1'b1;
                        wm_addr <= '0;
                        r_state <= S_LOADW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // Reads issue on counts 0..N_CLASS-1; each row lands one count later.
                S_LOADW: begin
                    if (int'(r_cnt) < N_CLASS - 1) begin
                        wm_re   <= 1'b1;
                        wm_addr <= CLW'(r_cnt + 1'b1);
                    end
                    if (int'(r_cnt) == N_CLASS) begin
                        r_cnt   <= '0;
                        fm_re   <= 1'b1;
                        fm_addr <= '0;
                        r_i     <= '0;
                        r_phase <= PH_ISSUE;
                        r_state <= S_XFORM;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_XFORM: case (r_phase)
                    PH_ISSUE: r_phase <= PH_CAP;
                    PH_CAP: begin
                        r_phase <= PH_MAC;
                        r_j     <= '0;
                        r_chunk <= '0;
                    end
                    default: if (w_last_chunk) begin
                        r_chunk <= '0;
                        if (w_last_cls) begin
                            r_j <= '0;
                            if (w_last_node) begin
                                r_i     <= '0;
                                r_state <= S_AGG;
                            end else begin
                                r_i     <= r_i + 1'b1;
                                fm_re   <= 1'b1;
                                fm_addr <= r_i + 1'b1;
                                r_phase <= PH_ISSUE;
                            end
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end else begin
                        r_chunk <= r_chunk + 1'b1;
                    end
                endcase
                S_AGG: if (w_last_cls) begin
                    r_j <= '0;
                    if (w_last_node) begin
                        r_i     <= '0;
                        r_state <= S_WRITE;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end else begin
                    r_j <= r_j + 1'b1;
                end
                S_WRITE: begin
                    y_we    <= 1'b1;
                    y_addr  <= r_i;
                    y_class <= w_best;
                    if (w_last_node) begin
                        r_i     <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FIN;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcn_engine.sv
// Directed bench for gcn_engine at default sizing: latency, class results,
// padding/out-of-range edges, ties, ignored start pulses and mid-run reset.
module tb_gcn_engine;

    localparam int NN  = 6;
    localparam int NC  = 3;
    localparam int NE  = 6;
    localparam int IW  = 3;
    localparam int RW  = 96 * 5;
    localparam int LAT = 263;

`ifdef GCN_SELF_LOOP_EN
    localparam int ISO_CLS = 2;
`else
    localparam int ISO_CLS = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [NE*IW-1:0]  coo_src;
    logic [NE*IW-1:0]  coo_dst;
    logic              fm_re;
    logic [2:0]        fm_addr;
    logic [RW-1:0]     fm_rdata;
    logic              wm_re;
    logic [1:0]        wm_addr;
    logic [RW-1:0]     wm_rdata;
    logic              y_we;
    logic [2:0]        y_addr;
    logic [1:0]        y_class;
    logic              busy;
    logic              done;

    logic [RW-1:0] feat_mem [NN];
    logic [RW-1:0] w_mem    [NC];

    int errors = 0;
    int checks = 0;
    int wr_total = 0;
    int done_total = 0;
    int wr_addr [64];
    int wr_cls  [64];
    int exp_cls [NN];

    gcn_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .coo_src  (coo_src),
        .coo_dst  (coo_dst),
        .fm_re    (fm_re),
        .fm_addr  (fm_addr),
        .fm_rdata (fm_rdata),
        .wm_re    (wm_re),
        .wm_addr  (wm_addr),
        .wm_rdata (wm_rdata),
        .y_we     (y_we),
        .y_addr   (y_addr),
        .y_class  (y_class),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM models: data valid the cycle after the read enable.
    always @(posedge clk) begin
        if (fm_re) fm_rdata <= feat_mem[fm_addr];
        if (wm_re) wm_rdata <= w_mem[wm_addr];
    end

    always @(negedge clk) begin
        if (y_we) begin
            if (wr_total < 64) begin
                wr_addr[wr_total] <= int'(y_addr);
                wr_cls[wr_total]  <= int'(y_class);
            end
            wr_total <= wr_total + 1;
        end
        if (done) done_total <= done_total + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] rowv(input logic [4:0] v);
        return {96{v}};
    endfunction

    task automatic set_edge(input int e, input int s, input int d);
        coo_src[e*IW +: IW] = IW'(s);
        coo_dst[e*IW +: IW] = IW'(d);
    endtask

    task automatic set_ring();
        for (int e = 0; e < NE; e++) set_edge(e, e + 1, (e + 1) % NN + 1);
    endtask

    task automatic set_feat_ones();
        for (int n = 0; n < NN; n++) feat_mem[n] = rowv(5'd1);
    endtask

    task automatic set_exp(input int c0, input int c1, input int c2,
                           input int c3, input int c4, input int c5);
        exp_cls[0] = c0; exp_cls[1] = c1; exp_cls[2] = c2;
        exp_cls[3] = c3; exp_cls[4] = c4; exp_cls[5] = c5;
    endtask

    task automatic run_job(input string tag, input bit inject);
        int lat;
        int wbase;
        int dbase;
        wbase = wr_total;
        dbase = done_total;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        check({tag, "_busy_on"}, 64'(busy), 64'd1);
        while (!done && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
            start = inject && (lat == 5 || lat == 100);
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_writes"}, 64'(wr_total - wbase), 64'd6);
        check({tag, "_done_pulses"}, 64'(done_total - dbase), 64'd1);
        for (int n = 0; n < NN; n++) begin
            if (wbase + n < 64) begin
                check($sformatf("%s_addr%0d", tag, n), 64'(wr_addr[wbase + n]), 64'(n));
                check($sformatf("%s_cls%0d", tag, n), 64'(wr_cls[wbase + n]), 64'(exp_cls[n]));
            end
        end
    endtask

    initial begin
        int wbase;
        int dbase;
        start   = 1'b0;
        coo_src = '0;
        coo_dst = '0;
        rst_n   = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({fm_re, wm_re, y_we, busy, done, fm_addr, wm_addr, y_addr, y_class}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ring graph, unit features, weight rows 1/2/3: T=(96,192,288) everywhere.
        // Stray start pulses at cycles 5 and 100 must be ignored.
        set_ring();
        set_feat_ones();
        w_mem[0] = rowv(5'd1);
        w_mem[1] = rowv(5'd2);
        w_mem[2] = rowv(5'd3);
        set_exp(2, 2, 2, 2, 2, 2);
        run_job("ring", 1'b1);

        // All-padding edge list: O is zero unless the diagonal is forced on.
        for (int e = 0; e < NE; e++) set_edge(e, 0, 0);
        set_exp(ISO_CLS, ISO_CLS, ISO_CLS, ISO_CLS, ISO_CLS, ISO_CLS);
        run_job("padding", 1'b0);

        // Rows 0 and 1 equal and dominant: tie goes to class 0.
        set_ring();
        w_mem[0] = rowv(5'd3);
        w_mem[1] = rowv(5'd3);
        w_mem[2] = rowv(5'd1);
        set_exp(0, 0, 0, 0, 0, 0);
        run_job("tie", 1'b0);

        // Out-of-range source 7 skipped, (1,2) kept, one half-padded slot.
        set_edge(0, 7, 1);
        set_edge(1, 1, 2);
        set_edge(2, 3, 0);
        set_edge(3, 0, 0);
        set_edge(4, 0, 0);
        set_edge(5, 0, 0);
        w_mem[0] = rowv(5'd1);
        w_mem[1] = rowv(5'd2);
        w_mem[2] = rowv(5'd3);
        set_exp(2, 2, ISO_CLS, ISO_CLS, ISO_CLS, ISO_CLS);
        run_job("out_of_range", 1'b0);

        // Self-edges only (A=I). Features: low half a, high half b.
        // W0 = 1 on low half, W1 = 1 on high half, W2 = 31 on elements 0 and 95,
        // so T = (48a, 48b, 31(a+b)).
        for (int e = 0; e < NE; e++) set_edge(e, e + 1, e + 1);
        feat_mem[0] = {{48{5'd1}},  {48{5'd2}}};
        feat_mem[1] = {{48{5'd3}},  {48{5'd1}}};
        feat_mem[2] = {{48{5'd1}},  {48{5'd1}}};
        feat_mem[3] = {{48{5'd0}},  {48{5'd0}}};
        feat_mem[4] = {{48{5'd31}}, {48{5'd31}}};
        feat_mem[5] = {{48{5'd2}},  {48{5'd5}}};
        w_mem[0] = {{48{5'd0}}, {48{5'd1}}};
        w_mem[1] = {{48{5'd1}}, {48{5'd0}}};
        w_mem[2] = '0;
        w_mem[2][4:0]       = 5'd31;
        w_mem[2][RW-1:RW-5] = 5'd31;
        set_exp(0, 1, 2, 0, 2, 0);
        run_job("self_feat", 1'b0);

        // Reset during XFORM: outputs clear at once, nothing is written afterwards.
        set_ring();
        set_feat_ones();
        w_mem[0] = rowv(5'd1);
        w_mem[1] = rowv(5'd2);
        w_mem[2] = rowv(5'd3);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #2;
        check("pre_reset_busy", 64'(busy), 64'd1);
        wbase = wr_total;
        dbase = done_total;
        rst_n = 1'b0;
        #1;
        check("abort_outputs",
              64'({fm_re, wm_re, y_we, busy, done, fm_addr, wm_addr, y_addr, y_class}), 64'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        #1;
        check("abort_no_writes", 64'(wr_total - wbase), 64'd0);
        check("abort_no_done", 64'(done_total - dbase), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        set_exp(2, 2, 2, 2, 2, 2);
        run_job("after_reset", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcn_engine.md
# gcn_engine

Parametrised successor to the fixed 6-node GCN inference block. It runs one graph-convolution layer, then an argmax classifier, over an N_NODES graph given as a COO edge list. It computes (A · (X · Wᵀ)) per node and writes the winning class index per node to the output memory. It sits between the feature/weight ROMs and the result memory, and is sequenced by a single start/done handshake.

## Interface
- N_NODES, 6, number of graph nodes (≥2)
- N_FEAT, 96, features per row
- N_CLASS, 3, output classes (≥2)
- N_EDGES, 6, COO edge slots
- BW, 5, unsigned element width
- LANES, 8, MACs per cycle; N_FEAT % LANES == 0 required
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- start  in  1  request pulse; accepted only in IDLE
- coo_src  in  N_EDGES*IW  1-based source indices, IW=$clog2(N_NODES+1); slot e at [e*IW+:IW]
- coo_dst  in  N_EDGES*IW  1-based destination indices
- fm_re  out  1  feature-row read enable
- fm_addr  out  $clog2(N_NODES)  feature row address
- fm_rdata  in  N_FEAT*BW  feature row, valid one cycle after fm_re
- wm_re  out  1  weight-row read enable
- wm_addr  out  $clog2(N_CLASS)  weight row address
- wm_rdata  in  N_FEAT*BW  weight row, valid one cycle after wm_re
- y_we  out  1  result write strobe
- y_addr  out  $clog2(N_NODES)  result node index
- y_class  out  $clog2(N_CLASS)  argmax class
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE → ADJ → LOADW → XFORM → AGG → WRITE → FIN → IDLE.
- IDLE: start=1 captures coo_src/coo_dst, clears the adjacency register, sets busy. start outside IDLE is ignored.
- ADJ: N_EDGES cycles, one slot per cycle. Sets adj[s-1][d-1] and adj[d-1][s-1]. A slot with s==0 or d==0 (padding), or any index >N_NODES, is skipped. Duplicate edges are idempotent.
- LOADW: issues N_CLASS weight reads, addresses 0..N_CLASS-1. Rows are held in an internal weight buffer. N_CLASS+1 cycles.
- XFORM: per node i: 1 cycle to issue fm_re, 1 cycle to capture the row, then per class j N_FEAT/LANES MAC cycles. Writes T[i][j].
- Arithmetic is unsigned. A product is 2*BW bits. T is TW=2*BW+$clog2(N_FEAT) bits; accumulation never truncates.
- AGG: one (i,j) per cycle, row-major. O[i][j] = Σk adj[i][k]·T[k][j], OW=TW+$clog2(N_NODES+1) bits. N_NODES*N_CLASS cycles.
- WRITE: one node per cycle, ascending i. y_we=1, y_addr=i, y_class=argmax_j O[i][j]. Ties resolve to the lowest class index.
- FIN: done=1 for one cycle; busy drops in the same cycle.

## Timing
- Latency: start accepted at edge 0; done is high during cycle L = N_EDGES + (N_CLASS+1) + N_NODES*(2+N_CLASS*N_FEAT/LANES) + N_NODES*N_CLASS + N_NODES + 1. Defaults give L=263.
- start is accepted on the cycle done is high? No: it is accepted in IDLE only, at the earliest the cycle after done.
- Reset values: fm_re, wm_re, y_we, busy, done = 0; all addresses and y_class = 0; state IDLE; adjacency cleared.
- Reset mid-operation aborts immediately. No further y_we is issued, and a partial result set is not completed.
- fm_re and wm_re are single-cycle pulses; addresses are valid in the same cycle.

## Configuration
- GCN_SELF_LOOP_EN defined: adj[i][i]=1 for all i at the end of ADJ, so A+I is used.
- GCN_SELF_LOOP_EN undefined: diagonal bits are set only by explicit self-edges (s==d) in the COO list.
- Latency is identical in both builds.

## Structure
- gcn_pkg holds:
  - state enum
  - width helper functions (IW, TW, OW)
  - the default parameter constants
- Sub-module gcn_dot_lanes: LANES-wide multiply plus adder tree plus accumulator, with clear/enable inputs. XFORM instantiates it once.
- Adjacency, T and O are flop arrays in gcn_engine.

## Test plan
- Default graph, edges (1,2)(2,3)(3,4)(4,5)(5,6)(6,1); all features 1; weight rows filled with 1, 2 and 3 → every T[i]=(96,192,288) → y_class=2 for all 6 nodes; done at cycle 263.
- Same data, edges all padding (0,0) → O all zero → y_class=0 for every node without GCN_SELF_LOOP_EN, and 2 with it.
- Tie: weight rows 0 and 1 identical and larger than row 2 → y_class=0.
- Out-of-range edge (7,1) plus valid (1,2): node 3 has no edge → O[3]=0 → y_class=0; node 1 → class 2.
- start pulsed at cycles 5 and 100 while busy → ignored; exactly 6 y_we writes; one done pulse.
- rst_n dropped during XFORM (cycle 50) → all outputs 0 at once, no y_we; a fresh start afterwards completes normally in 263 cycles.
